// File: rtl/piso_ctrl_if.sv
// Word handshake and shift-register control bundle between a word source,
// piso_ctrl and the parallel-in/serial-out shift register.
interface piso_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  s_valid_i;
   logic                  s_ready_o;
   logic [DATA_WIDTH-1:0] s_data_i;
   logic                  piso_wr_en_o;
   logic                  piso_en_o;
   logic [DATA_WIDTH-1:0] piso_data_o;
   logic                  frame_o;
   logic                  last_o;
   logic                  busy_o;

   // Word source / observer side
   modport master (
      output s_valid_i,
      output s_data_i,
      input  s_ready_o,
      input  piso_wr_en_o,
      input  piso_en_o,
      input  piso_data_o,
      input  frame_o,
      input  last_o,
      input  busy_o
   );

   // Controller side
   modport slave (
      input  s_valid_i,
      input  s_data_i,
      output s_ready_o,
      output piso_wr_en_o,
      output piso_en_o,
      output piso_data_o,
      output frame_o,
      output last_o,
      output busy_o
   );
endinterface

// File: rtl/piso_ctrl.sv
// Sequencer for an MSB-first PISO shift register: accepts a word, issues one
// load strobe, paces DATA_WIDTH-1 shift strobes, then an optional idle gap.
module piso_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_BITS   = 1
) (
   input  logic       clk_i,
   input  logic       a_rst_i,
   input  logic       abort_i,
   piso_ctrl_if.slave bus
);
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int unsigned GAP_CYC  = GAP_BITS * CLK_DIV;
   localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_END = BIT_W'(DATA_WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_LAST);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t                r_state;
   logic [DIV_W-1:0]      r_div_cnt;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [GAP_W-1:0]      r_gap_cnt;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_armed;

   logic w_div_wrap;
   logic w_bit_last;
   logic w_shift;
   logic w_ready;
   logic w_hs;

   assign w_div_wrap = (r_div_cnt == DIV_END);
   assign w_bit_last = (r_bit_cnt == BIT_END);
   assign w_shift    = (r_state == ST_SHIFT);
   // r_armed holds ready low through reset until the first edge after release
   assign w_ready    = (r_state == ST_IDLE) && r_armed && !abort_i;
   assign w_hs       = bus.s_valid_i && w_ready;

   // Only abort_i gates the state decode; the last bit period issues no shift
   assign bus.s_ready_o    = w_ready;
   assign bus.piso_wr_en_o = (r_state == ST_LOAD) && !abort_i;
   assign bus.piso_en_o    = w_shift && w_div_wrap && !w_bit_last && !abort_i;
   assign bus.frame_o      = w_shift && !abort_i;
   assign bus.last_o       = w_shift && w_bit_last && !abort_i;
   assign bus.busy_o       = (r_state != ST_IDLE);
   assign bus.piso_data_o  = r_data;

   always_ff @(posedge clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         r_state   <= ST_IDLE;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_data    <= '0;
         r_armed   <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         if (abort_i) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  if (w_hs) begin
                     r_data  <= bus.s_data_i;
                     r_state <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  r_div_cnt <= '0;
                  r_bit_cnt <= '0;
                  r_state   <= ST_SHIFT;
               end
               ST_SHIFT: begin
                  if (w_div_wrap) begin
                     r_div_cnt <= '0;
                     if (w_bit_last) begin
                        r_bit_cnt <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                     end
                  end else begin
                     r_div_cnt <= r_div_cnt + DIV_W'(1);
                  end
               end
               ST_GAP: begin
                  if (r_gap_cnt == GAP_END) begin
                     r_gap_cnt <= '0;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_piso_ctrl.sv
// Randomized bench for piso_ctrl: two instances (CLK_DIV=4/GAP=1 and CLK_DIV=1/GAP=0)
// checked each cycle against a timeline model plus a shift-register model.
module tb_piso_ctrl;
   localparam int unsigned DW   = 8;
   localparam int unsigned CD0  = 4;
   localparam int unsigned GB0  = 1;
   localparam int unsigned CD1  = 1;
   localparam int unsigned GB1  = 0;
   localparam int          NCYC = 3000;

   typedef struct packed {
      logic ready;
      logic wr;
      logic en;
      logic frame;
      logic last;
      logic busy;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   logic abort0;
   logic abort1;

   piso_ctrl_if #(.DATA_WIDTH(DW)) bus0 ();
   piso_ctrl_if #(.DATA_WIDTH(DW)) bus1 ();

   piso_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(CD0), .GAP_BITS(GB0)) u_dut0 (
      .clk_i   (clk),
      .a_rst_i (rst),
      .abort_i (abort0),
      .bus     (bus0)
   );

   piso_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(CD1), .GAP_BITS(GB1)) u_dut1 (
      .clk_i   (clk),
      .a_rst_i (rst),
      .abort_i (abort1),
      .bus     (bus1)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model state: m_off = cycles since the accepting handshake, -1 when idle
   int            m_off   [2];
   bit            m_armed [2];
   logic [DW-1:0] m_word  [2];
   logic [DW-1:0] m_sreg  [2];
   int            n_hs    [2];
   bit            did_ab  [2];
   bit            did_rst;

   bit            v  [2];
   bit            ab [2];
   logic [DW-1:0] d  [2];
   logic [DW-1:0] dir_words [4];

   function automatic obs_t obs_of(input int i);
      if (i == 0)
         return {bus0.s_ready_o, bus0.piso_wr_en_o, bus0.piso_en_o,
                 bus0.frame_o, bus0.last_o, bus0.busy_o};
      return {bus1.s_ready_o, bus1.piso_wr_en_o, bus1.piso_en_o,
              bus1.frame_o, bus1.last_o, bus1.busy_o};
   endfunction

   function automatic logic [DW-1:0] data_of(input int i);
      return (i == 0) ? bus0.piso_data_o : bus1.piso_data_o;
   endfunction

   task automatic drive();
      bus0.s_valid_i = v[0];
      bus0.s_data_i  = d[0];
      abort0         = ab[0];
      bus1.s_valid_i = v[1];
      bus1.s_data_i  = d[1];
      abort1         = ab[1];
   endtask

   task automatic reset_model();
      for (int i = 0; i < 2; i++) begin
         m_off[i]   = -1;
         m_armed[i] = 1'b0;
         m_word[i]  = '0;
         v[i]       = 1'b0;
         ab[i]      = 1'b0;
      end
   endtask

   // Expected outputs from the word timeline, then advance the model one edge
   task automatic eval_update(input int i);
      obs_t          g;
      obs_t          e;
      logic [DW-1:0] gd;
      int            cd, gb, off, k, ph, last_off;
      bit            idle, sh, hs;
      cd       = (i == 0) ? int'(CD0) : int'(CD1);
      gb       = (i == 0) ? int'(GB0) : int'(GB1);
      g        = obs_of(i);
      gd       = data_of(i);
      off      = m_off[i];
      idle     = (off < 0);
      sh       = (off >= 2) && (off <= 1 + int'(DW) * cd);
      k        = sh ? (off - 2) / cd : 0;
      ph       = sh ? (off - 2) % cd : 0;
      last_off = 1 + (int'(DW) + gb) * cd;

      e.ready = idle && m_armed[i] && !ab[i];
      e.wr    = (off == 1) && !ab[i];
      e.en    = sh && (ph == cd - 1) && (k < int'(DW) - 1) && !ab[i];
      e.frame = sh && !ab[i];
      e.last  = sh && (k == int'(DW) - 1) && !ab[i];
      e.busy  = !idle;

      chk($sformatf("d%0d_ctl off=%0d ab=%0d", i, off, ab[i]), 32'(g), 32'(e));
      chk($sformatf("d%0d_data", i), 32'(gd), 32'(m_word[i]));
      chk($sformatf("d%0d_wr_en_overlap", i), 32'(g.wr & g.en), 32'd0);
      if (sh)
         chk($sformatf("d%0d_serial bit=%0d", i, k), 32'(m_sreg[i][DW-1]),
             32'(m_word[i][int'(DW) - 1 - k]));

      // Shift register driven by the DUT's own strobes, en has priority
      if (g.en)
         m_sreg[i] = {m_sreg[i][DW-2:0], 1'b0};
      else if (g.wr)
         m_sreg[i] = gd;

      hs = v[i] && e.ready;
      if (hs) begin
         m_word[i] = d[i];
         n_hs[i]++;
         v[i] = 1'b0;
      end
      if (ab[i] || (!idle && off == last_off))
         m_off[i] = -1;
      else if (idle)
         m_off[i] = hs ? 1 : -1;
      else
         m_off[i] = off + 1;
      m_armed[i] = 1'b1;
   endtask

   // Directed words first, then a mid-word abort, an abort alongside valid, then random
   task automatic gen_stim(input int i);
      int ab_off;
      ab_off = (i == 0) ? 15 : 5;
      if (n_hs[i] < 4) begin
         ab[i] = 1'b0;
         if (!v[i]) begin
            v[i] = 1'b1;
            d[i] = dir_words[n_hs[i]];
         end
      end else if (n_hs[i] == 4) begin
         ab[i] = 1'b0;
         if (!did_ab[i] && m_off[i] == ab_off) begin
            ab[i]     = 1'b1;
            did_ab[i] = 1'b1;
         end else if (did_ab[i] && m_off[i] < 0 && !v[i]) begin
            ab[i] = 1'b1;
            v[i]  = 1'b1;
            d[i]  = 8'h3C;
         end
      end else begin
         ab[i] = ($urandom_range(0, 29) == 0);
         if (!v[i]) begin
            v[i] = ($urandom_range(0, 3) != 0);
            d[i] = DW'($urandom);
         end
      end
   endtask

   initial begin
      dir_words[0] = 8'hA5;
      dir_words[1] = 8'hFF;
      dir_words[2] = 8'h00;
      dir_words[3] = 8'hA5;
      did_rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_sreg[i] = '0;
         n_hs[i]   = 0;
         did_ab[i] = 1'b0;
         d[i]      = '0;
      end
      rst = 1'b1;
      reset_model();
      drive();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("d%0d_reset_ctl", i), 32'(obs_of(i)), 32'd0);
         chk($sformatf("d%0d_reset_data", i), 32'(data_of(i)), 32'd0);
      end
      #2 rst = 1'b0;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         eval_update(0);
         eval_update(1);
         @(posedge clk);
         #1;
         if (!did_rst && cyc > 400 && m_off[0] == 10) begin
            // Asynchronous reset in the middle of a SHIFT bit period
            did_rst = 1'b1;
            reset_model();
            drive();
            #2 rst = 1'b1;
            #1;
            for (int i = 0; i < 2; i++) begin
               chk($sformatf("d%0d_async_rst_ctl", i), 32'(obs_of(i)), 32'd0);
               chk($sformatf("d%0d_async_rst_data", i), 32'(data_of(i)), 32'd0);
            end
            @(posedge clk);
            #3;
            chk("d0_rst_hold_ctl", 32'(obs_of(0)), 32'd0);
            rst = 1'b0;
         end else begin
            gen_stim(0);
            gen_stim(1);
            drive();
         end
      end

      chk("d0_words_accepted", 32'(n_hs[0] >= 20), 32'd1);
      chk("d1_words_accepted", 32'(n_hs[1] >= 40), 32'd1);
      chk("d0_directed_abort", 32'(did_ab[0]), 32'd1);
      chk("d1_directed_abort", 32'(did_ab[1]), 32'd1);
      chk("async_reset_done", 32'(did_rst), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
